// File: rtl/vwb_sequencer.sv
// vwb_sequencer: splits a register-group writeback result into one
// register-file write per cycle. Consecutive groups can follow each other
// without a gap, and illegal or misaligned results are dropped with an err pulse.
module vwb_sequencer #(
    parameter int VLEN   = 32,
    parameter int NREG   = 32,
    parameter int MAXGRP = 8,
    localparam int WB_W  = VLEN * MAXGRP,
    localparam int AW    = $clog2(NREG),
    localparam int BW    = VLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_data,
    input  logic [WB_W/8-1:0] in_be,
    input  logic [AW-1:0]     in_vd,
    input  logic [2:0]        in_vlmul,
    output logic              rf_we,
    output logic [AW-1:0]     rf_addr,
    output logic [VLEN-1:0]   rf_wdata,
    output logic [BW-1:0]     rf_be,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] MAXG = 4'(MAXGRP);

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          k_q, k_d;
    logic [2:0]          last_q, last_d;
    logic [WB_W-1:0]     data_q, data_d;
    logic [WB_W/8-1:0]   be_q, be_d;
    logic [AW-1:0]       vd_q, vd_d;
    logic                rf_we_q, rf_we_d;
    logic [AW-1:0]       rf_addr_q, rf_addr_d;
    logic [VLEN-1:0]     rf_wdata_q, rf_wdata_d;
    logic [BW-1:0]       rf_be_q, rf_be_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [3:0]          grp;
    logic [AW-1:0]       vd_mask;
    logic                illegal;
    logic                on_last;
    logic                accept;

    // Next-state and next-output logic. In WRITE, the rf_* registers already
    // hold write k, so the cycle with k == last is the one that issues the
    // final write. A new group accepted in that cycle loads its first write
    // directly into the rf_* registers, which removes any bubble between groups.
    always_comb begin
        grp     = 4'd1 << in_vlmul[1:0];
        vd_mask = AW'(grp - 4'd1);
        illegal = in_vlmul[2] | (grp > MAXG) | ((in_vd & vd_mask) != '0);
        on_last = (state_q == WRITE) && (k_q == last_q);
        in_ready = rst_n & ((state_q == IDLE) | on_last);
        accept  = in_valid & in_ready;

        state_d    = state_q;
        k_d        = k_q;
        last_d     = last_q;
        data_d     = data_q;
        be_d       = be_q;
        vd_d       = vd_q;
        rf_we_d    = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        rf_be_d    = '0;
        err_d      = 1'b0;

        if (accept) begin
            k_d = '0;
            if (illegal) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                state_d    = WRITE;
                data_d     = in_data;
                be_d       = in_be;
                vd_d       = in_vd;
                last_d     = 3'(grp - 4'd1);
                rf_we_d    = 1'b1;
                rf_addr_d  = in_vd;
                rf_wdata_d = in_data[VLEN-1:0];
                rf_be_d    = in_be[BW-1:0];
            end
        end else if (state_q == WRITE) begin
            if (on_last) begin
                state_d = IDLE;
                k_d     = '0;
            end else begin
                k_d        = k_q + 3'd1;
                rf_we_d    = 1'b1;
                rf_addr_d  = vd_q + AW'(k_d);
                rf_wdata_d = data_q[int'(k_d) * VLEN +: VLEN];
                rf_be_d    = be_q[int'(k_d) * BW +: BW];
            end
        end

        busy_d = rf_we_d;
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            last_q     <= '0;
            data_q     <= '0;
            be_q       <= '0;
            vd_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            rf_be_q    <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            last_q     <= last_d;
            data_q     <= data_d;
            be_q       <= be_d;
            vd_q       <= vd_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            rf_be_q    <= rf_be_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_addr  = rf_addr_q;
    assign rf_wdata = rf_wdata_q;
    assign rf_be    = rf_be_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vwb_sequencer.sv
// Testbench for vwb_sequencer with default parameters. Each scenario queues
// the per-cycle expected outputs and then compares them against the DUT
// at every falling edge.
module tb_vwb_sequencer;

    localparam int VLEN = 32;
    localparam int NREG = 32;
    localparam int MAXGRP = 8;
    localparam int WB_W = VLEN * MAXGRP;
    localparam int AW = 5;
    localparam int BW = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WB_W-1:0]   in_data;
    logic [WB_W/8-1:0] in_be;
    logic [AW-1:0]     in_vd;
    logic [2:0]        in_vlmul;
    logic              rf_we;
    logic [AW-1:0]     rf_addr;
    logic [VLEN-1:0]   rf_wdata;
    logic [BW-1:0]     rf_be;
    logic              busy;
    logic              err;

    // {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready}
    logic [44:0] exp_q[$];
    logic [44:0] exp_v;
    logic [44:0] obs_v;
    int checks;
    int errors;

    vwb_sequencer #(.VLEN(VLEN), .NREG(NREG), .MAXGRP(MAXGRP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_be(in_be), .in_vd(in_vd), .in_vlmul(in_vlmul),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_be(rf_be),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_exp(input logic we, input logic [4:0] a,
                                     input logic [31:0] d, input logic [3:0] b,
                                     input logic e, input logic r);
        exp_q.push_back({we, we, a, d, b, e, r});
    endfunction

    function automatic void push_idle(input logic r);
        exp_q.push_back({2'b00, 5'd0, 32'd0, 4'd0, 1'b0, r});
    endfunction

    function automatic logic [WB_W-1:0] mkdata(input logic [31:0] base);
        logic [WB_W-1:0] d;
        d = '0;
        for (int unsigned k = 0; k < 8; k++) d[k*32 +: 32] = base + 32'(k);
        return d;
    endfunction

    task automatic offer(input logic [2:0] lm, input logic [4:0] vd,
                         input logic [WB_W-1:0] d, input logic [31:0] be);
        in_valid = 1'b1;
        in_vlmul = lm;
        in_vd    = vd;
        in_data  = d;
        in_be    = be;
    endtask

    // Reset held with in_valid high: nothing transfers, outputs zero, ready low.
    task automatic test_reset();
        push_idle(1'b0); push_idle(1'b0); push_idle(1'b1); push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd0, 5'd1, mkdata(32'h55), '1);
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL reset: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL reset: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // One-register group.
    task automatic test_single();
        logic [WB_W-1:0] d;
        d = '0;
        d[31:0] = 32'hDEADBEEF;
        push_idle(1'b1);
        push_exp(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd0, 5'd5, d, '1);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL single: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL single: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // Eight-register group; in_valid is held with changing junk while ready is low.
    task automatic test_group8();
        push_idle(1'b1);
        for (int unsigned k = 0; k < 8; k++)
            push_exp(1'b1, 5'(8 + k), 32'h1000 + 32'(k), 4'hF, 1'b0, k == 7);
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd3, 5'd8, mkdata(32'h1000), '1);
                for (int unsigned j = 0; j < 7; j++) begin
                    @(posedge clk); #1;
                    offer(3'($urandom_range(0, 3)), 5'($urandom), {8{32'($urandom)}}, '1);
                end
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (10) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL group8: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL group8: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // Misaligned base, then an out-of-range vlmul, back to back.
    task automatic test_illegal();
        push_idle(1'b1);
        exp_q.push_back({2'b00, 5'd0, 32'd0, 4'd0, 1'b1, 1'b1});
        exp_q.push_back({2'b00, 5'd0, 32'd0, 4'd0, 1'b1, 1'b1});
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd2, 5'd6, mkdata(32'h77), '1);
                @(posedge clk); #1;
                offer(3'd5, 5'd0, mkdata(32'h88), '1);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (4) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL illegal: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL illegal: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // Two 2-register groups; the second is offered early and is taken on the last write.
    task automatic test_back_to_back();
        push_idle(1'b1);
        push_exp(1'b1, 5'd2, 32'hA0, 4'hF, 1'b0, 1'b0);
        push_exp(1'b1, 5'd3, 32'hA1, 4'hF, 1'b0, 1'b1);
        push_exp(1'b1, 5'd4, 32'hB0, 4'hF, 1'b0, 1'b0);
        push_exp(1'b1, 5'd5, 32'hB1, 4'hF, 1'b0, 1'b1);
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd1, 5'd2, mkdata(32'hA0), '1);
                @(posedge clk); #1;
                offer(3'd1, 5'd4, mkdata(32'hB0), '1);
                @(posedge clk); @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (6) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL back_to_back: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL back_to_back: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // Four-register group where slice k=1 has no byte enables.
    task automatic test_zero_be();
        push_idle(1'b1);
        push_exp(1'b1, 5'd0, 32'h2000, 4'hF, 1'b0, 1'b0);
        push_exp(1'b1, 5'd1, 32'h2001, 4'h0, 1'b0, 1'b0);
        push_exp(1'b1, 5'd2, 32'h2002, 4'hF, 1'b0, 1'b0);
        push_exp(1'b1, 5'd3, 32'h2003, 4'hF, 1'b0, 1'b1);
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd2, 5'd0, mkdata(32'h2000), 32'hFFFF_FF0F);
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                repeat (6) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL zero_be: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL zero_be: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    // Reset sampled at the end of the second write of an 8-register group.
    task automatic test_reset_mid();
        push_idle(1'b1);
        push_exp(1'b1, 5'd16, 32'h3000, 4'hF, 1'b0, 1'b0);
        push_exp(1'b1, 5'd17, 32'h3001, 4'hF, 1'b0, 1'b0);
        push_idle(1'b0);
        push_idle(1'b1);
        push_idle(1'b1);
        fork
            begin
                @(posedge clk); #1;
                offer(3'd3, 5'd16, mkdata(32'h3000), '1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
            end
            begin
                @(posedge clk);
                repeat (6) begin
                    @(negedge clk);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL reset_mid: scoreboard empty, got %h", {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready});
                    end else begin
                        exp_v = exp_q.pop_front();
                        obs_v = {rf_we, busy, rf_addr, rf_wdata, rf_be, err, in_ready};
                        if (obs_v !== exp_v) begin
                            errors++;
                            $display("FAIL reset_mid: got %h expected %h", obs_v, exp_v);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_be    = '0;
        in_vd    = '0;
        in_vlmul = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_single();
        test_group8();
        test_illegal();
        test_back_to_back();
        test_zero_be();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vwb_sequencer.md
VWB_SEQUENCER -- requirements
Module: vwb_sequencer

Interface
REQ-001 Parameter VLEN, default 32, bit width of one vector register.
REQ-002 Parameter NREG, default 32, number of vector registers; power of two, at least 8.
REQ-003 Parameter MAXGRP, default 8, largest register group; power of two, at most 8, at most NREG.
REQ-004 Derived: WB_W = VLEN*MAXGRP; AW = clog2(NREG); BW = VLEN/8 (VLEN a multiple of 8).
REQ-005 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port: in_valid  in  1  writeback result offered.
REQ-008 Port: in_ready  out  1  sequencer accepts a result this cycle.
REQ-009 Port: in_data  in  WB_W  result; register k of the group occupies bits [k*VLEN +: VLEN].
REQ-010 Port: in_be  in  WB_W/8  byte enables, laid out the same way as in_data.
REQ-011 Port: in_vd  in  AW  base destination register.
REQ-012 Port: in_vlmul  in  3  group size code; 0..3 selects 1/2/4/8 registers.
REQ-013 Port: rf_we  out  1  register-file write strobe.
REQ-014 Port: rf_addr  out  AW  register written.
REQ-015 Port: rf_wdata  out  VLEN  write data.
REQ-016 Port: rf_be  out  BW  byte enables for rf_wdata.
REQ-017 Port: busy  out  1  high while a group write is in progress.
REQ-018 Port: err  out  1  one-cycle pulse when a result is rejected.

Function
REQ-019 The sequencer SHALL implement a two-state FSM, IDLE and WRITE; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-020 Group size G SHALL be 1<<in_vlmul; a transfer is illegal if in_vlmul>3, G>MAXGRP, or in_vd is not a multiple of G.
REQ-021 An illegal transfer SHALL be consumed without any rf_we, SHALL pulse err high for exactly the next cycle, and SHALL leave the FSM in (or return it to) IDLE.
REQ-022 A legal transfer SHALL capture in_data, in_be, in_vd and G into internal registers, set index k=0, and enter WRITE.
REQ-023 In WRITE, each cycle SHALL drive rf_we=1, rf_addr=vd+k, rf_wdata=data[k*VLEN +: VLEN], rf_be=be[k*BW +: BW], then increment k.
REQ-024 The first write SHALL appear the cycle after acceptance; a group of G registers SHALL occupy exactly G consecutive cycles.
REQ-025 All rf_* outputs, busy and err SHALL be registered; rf_addr, rf_wdata and rf_be SHALL be zero whenever rf_we=0.
REQ-026 rf_we SHALL be asserted even when its rf_be slice is all zero, and the write SHALL still consume its cycle.
REQ-027 in_ready SHALL be high in IDLE and during the cycle that issues the last write of a group (k=G-1); it SHALL be low otherwise.
REQ-028 A transfer accepted during the last write SHALL start its own first write on the very next cycle, giving back-to-back groups with no bubble.
REQ-029 An illegal transfer accepted during the last write SHALL pulse err on the next cycle, with rf_we=0 and the FSM in IDLE.
REQ-030 busy SHALL be high exactly in the cycles where rf_we=1.
REQ-031 Inputs SHALL be ignored in cycles where in_valid and in_ready are not both high; a held in_valid with changing inputs SHALL have no effect while in_ready=0.
REQ-032 rf_addr SHALL never wrap: the alignment rule together with power-of-two NREG guarantees vd+G-1 < NREG.

Reset
REQ-033 While rst_n=0 at a rising edge, the FSM SHALL go to IDLE, k SHALL clear, and rf_we, rf_addr, rf_wdata, rf_be, busy and err SHALL be 0.
REQ-034 in_ready SHALL be 0 during any cycle where rst_n=0.
REQ-035 Reset asserted mid-group SHALL abort the remaining writes with no further rf_we; the captured result is discarded.
REQ-036 No transfer SHALL occur in a cycle where rst_n=0, regardless of in_valid.

Verification
REQ-037 Defaults; vlmul=0, vd=5, data[31:0]=0xDEADBEEF, be=all ones -> one cycle later rf_we=1, addr=5, wdata=0xDEADBEEF, rf_be=0xF; then idle.
REQ-038 vlmul=3, vd=8, register k's word = 0x1000+k -> 8 consecutive writes, addr 8..15, data 0x1000..0x1007; in_ready high only in IDLE and on the addr-15 cycle.
REQ-039 vlmul=2, vd=6 (misaligned), then vlmul=5 -> each gives an err pulse with no rf_we; in_ready stays high.
REQ-040 Back-to-back: vlmul=1 at vd=2, second vlmul=1 at vd=4 offered during the addr-3 write -> addrs 2,3,4,5 in four consecutive cycles with busy high throughout.
REQ-041 vlmul=2 at vd=0, be slice for k=1 is 0x0 and the rest all ones -> four writes with rf_be 0xF, 0x0, 0xF, 0xF.
REQ-042 rst_n=0 in the cycle after the second write of a vlmul=3 group -> no rf_we after reset; outputs zero; in_ready=1 the first cycle after rst_n returns high.
